// File: rtl/adc_sample_filter.sv
// adc_sample_filter: per-channel moving-average filter for the side and diagonal ADC sensors.
// Each channel keeps a 2^WINDOW_LOG2 circular buffer and a running sum; output is floor(sum / N).
// Optional macro ADC_NEG_CLAMP_EN: replaces negative samples with 0 before they enter the window.
module adc_sample_filter #(
    parameter int WINDOW_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic        sample_channel,
    input  logic [15:0] sample_data,
    output logic [15:0] side_adc_data,
    output logic [15:0] diag_adc_data,
    output logic        side_valid,
    output logic        diag_valid,
    output logic        side_primed,
    output logic        diag_primed
);
    localparam int N  = 1 << WINDOW_LOG2;
    localparam int SW = 16 + WINDOW_LOG2;
    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(N);

    logic signed [15:0]      buf_q [2][N];
    logic signed [SW-1:0]    sum_q [2];
    logic [WINDOW_LOG2-1:0]  ptr_q [2];
    logic [CW-1:0]           cnt_q [2];
    logic [15:0]             out_q [2];
    logic                    vld_q [2];

    logic signed [15:0]      smp;
    logic signed [SW-1:0]    sum_d;
    logic [CW-1:0]           cnt_d;

`ifdef ADC_NEG_CLAMP_EN
    assign smp = sample_data[15] ? 16'sd0 : sample_data;
`else
    assign smp = sample_data;
`endif

    // Next running sum and fill count for the channel addressed by this sample.
    always_comb begin
        sum_d = sum_q[sample_channel] - buf_q[sample_channel][ptr_q[sample_channel]] + smp;
        cnt_d = (cnt_q[sample_channel] == FULL) ? FULL : cnt_q[sample_channel] + 1'b1;
    end

    // Window state and registered outputs; only the addressed channel changes on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < N; i++) buf_q[c][i] <= '0;
                sum_q[c] <= '0;
                ptr_q[c] <= '0;
                cnt_q[c] <= '0;
                out_q[c] <= '0;
                vld_q[c] <= 1'b0;
            end
        end else begin
            vld_q[0] <= 1'b0;
            vld_q[1] <= 1'b0;
            if (sample_valid) begin
                buf_q[sample_channel][ptr_q[sample_channel]] <= smp;
                sum_q[sample_channel] <= sum_d;
                ptr_q[sample_channel] <= ptr_q[sample_channel] + 1'b1;
                cnt_q[sample_channel] <= cnt_d;
                out_q[sample_channel] <= sum_d[WINDOW_LOG2 +: 16];
                vld_q[sample_channel] <= (cnt_d == FULL);
            end
        end
    end

    assign side_adc_data = out_q[0];
    assign diag_adc_data = out_q[1];
    assign side_valid    = vld_q[0];
    assign diag_valid    = vld_q[1];
    assign side_primed   = (cnt_q[0] == FULL);
    assign diag_primed   = (cnt_q[1] == FULL);
endmodule

// File: tb/tb_adc_sample_filter.sv
// tb_adc_sample_filter: directed vector table plus randomized run against a queue-based averaging model.
module tb_adc_sample_filter;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset, sample_valid, sample_channel;
    logic [15:0] sample_data;
    logic [15:0] side_adc_data, diag_adc_data;
    logic        side_valid, diag_valid, side_primed, diag_primed;

    always #5 clk = ~clk;

    adc_sample_filter #(.WINDOW_LOG2(3)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .sample_channel(sample_channel), .sample_data(sample_data),
        .side_adc_data(side_adc_data), .diag_adc_data(diag_adc_data),
        .side_valid(side_valid), .diag_valid(diag_valid),
        .side_primed(side_primed), .diag_primed(diag_primed)
    );

    typedef struct {
        bit          rst, v, ch;
        logic [15:0] d;
        logic [35:0] exp;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;
    int   mq[2][$];
    int   mo[2];
    bit   mv[2];

    task automatic add(bit r, bit v, bit ch, logic [15:0] d, logic [15:0] es, logic [15:0] ed,
                       bit sv, bit dv, bit sp, bit dp);
        vec_t t;
        t.rst = r; t.v = v; t.ch = ch; t.d = d;
        t.exp = {es, ed, sv, dv, sp, dp};
        tv.push_back(t);
    endtask

    task automatic drive(bit r, bit v, bit ch, logic [15:0] d);
        reset = r; sample_valid = v; sample_channel = ch; sample_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(string nm, logic [35:0] exp);
        logic [35:0] act;
        act = {side_adc_data, diag_adc_data, side_valid, diag_valid, side_primed, diag_primed};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got side=%h diag=%h sv=%b dv=%b sp=%b dp=%b expected side=%h diag=%h sv=%b dv=%b sp=%b dp=%b",
                     nm, act[35:20], act[19:4], act[3], act[2], act[1], act[0],
                     exp[35:20], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic int fdiv(int s);
        return (s >= 0) ? s / N : -((-s + N - 1) / N);
    endfunction

    function automatic int stored(logic [15:0] d);
        int s;
        s = int'($signed(d));
`ifdef ADC_NEG_CLAMP_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic model(bit r, bit v, bit ch, logic [15:0] d);
        int s;
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                mq[c].delete();
                mo[c] = 0;
                mv[c] = 1'b0;
            end
        end else begin
            mv[0] = 1'b0;
            mv[1] = 1'b0;
            if (v) begin
                s = 0;
                mq[ch].push_back(stored(d));
                if (mq[ch].size() > N) void'(mq[ch].pop_front());
                foreach (mq[ch][i]) s += mq[ch][i];
                mo[ch] = fdiv(s);
                mv[ch] = (mq[ch].size() == N);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_channel = 1'b0; sample_data = '0;

        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 16'h1000, 16'(k * 'h200), 16'h0000, k == 8, 0, k == 8, 0);
        add(0, 1, 0, 16'h1800, 16'h1100, 16'h0000, 1, 0, 1, 0);
        add(0, 0, 1, 16'h7FFF, 16'h1100, 16'h0000, 0, 0, 1, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 1, 0, 16'h0800, 16'(k * 'h100), 16'((k - 1) * 'h400), k == 8, 0, k == 8, 0);
            add(0, 1, 1, 16'h2000, 16'(k * 'h100), 16'(k * 'h400), 0, k == 8, k == 8, k == 8);
        end
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
`ifdef ADC_NEG_CLAMP_EN
            add(0, 1, 0, 16'hFFF0, 16'h0000, 16'h0000, k == 8, 0, k == 8, 0);
`else
            add(0, 1, 0, 16'hFFF0, 16'(-2 * k), 16'h0000, k == 8, 0, k == 8, 0);
`endif
        end
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            add(0, 1, 0, 16'h1000, 16'(k * 'h200), 16'h0000, 0, 0, 0, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0800, 16'h0100, 16'h0000, 0, 0, 0, 0);
        add(1, 1, 0, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 1, 16'h8000, 16'h0000, 16'h0000, 0, 0, 0, 0);

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].v, tv[i].ch, tv[i].d);
            cmp($sformatf("vec%0d", i), tv[i].exp);
        end

        model(1, 0, 0, '0);
        drive(1, 0, 0, '0);
        for (int n = 0; n < 3000; n++) begin
            bit r, v, ch;
            logic [15:0] d;
            r  = ($urandom_range(199) == 0);
            v  = ($urandom_range(9) < 7);
            ch = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            model(r, v, ch, d);
            drive(r, v, ch, d);
            cmp($sformatf("rand%0d", n),
                {16'(mo[0]), 16'(mo[1]), mv[0], mv[1], mq[0].size() == N, mq[1].size() == N});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_filter.md
ADC_SAMPLE_FILTER -- requirements
Module: adc_sample_filter

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 3: log2 of the averaging window depth per channel, legal range 1..5.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sample_valid  input  1  one raw ADC conversion present this cycle.
REQ-005 SHALL have port sample_channel  input  1  0 = side sensor, 1 = diagonal sensor.
REQ-006 SHALL have port sample_data  input  16  raw signed two's-complement conversion result.
REQ-007 SHALL have port side_adc_data  output  16  signed filtered side value, feeding the distance lookup stage.
REQ-008 SHALL have port diag_adc_data  output  16  signed filtered diagonal value, feeding the distance lookup stage.
REQ-009 SHALL have port side_valid  output  1  one-cycle pulse: side_adc_data updated and window full.
REQ-010 SHALL have port diag_valid  output  1  one-cycle pulse: diag_adc_data updated and window full.
REQ-011 SHALL have port side_primed  output  1  level: side window has received at least 2^WINDOW_LOG2 samples since reset.
REQ-012 SHALL have port diag_primed  output  1  level: diag window has received at least 2^WINDOW_LOG2 samples since reset.

Function
REQ-013 SHALL keep, per channel, an N = 2^WINDOW_LOG2 entry circular sample buffer, a write pointer, a signed running sum of 16+WINDOW_LOG2 bits, and a fill counter saturating at N.
REQ-014 SHALL accept a sample on every cycle with sample_valid=1, back-to-back, without stall or drop; there is no ready output.
REQ-015 SHALL, on accept, compute sum_next = sum - buf[ptr] + sample, write sample into buf[ptr], and advance ptr modulo N, wrapping from N-1 to 0.
REQ-016 SHALL register the selected channel output as sum_next arithmetically shifted right by WINDOW_LOG2 (floor toward negative infinity), visible the cycle after accept (latency 1).
REQ-017 SHALL leave the unselected channel's buffer, sum, pointer, counter and output unchanged.
REQ-018 SHALL pulse the channel's valid for exactly one cycle with the output update only if the fill counter after the accept equals N; updates before that change the output with valid held 0.
REQ-019 SHALL assert the channel's primed flag in the same cycle as the first valid pulse and hold it until reset.
REQ-020 SHALL never overflow the running sum: the width in REQ-013 holds N full-scale samples exactly.
REQ-021 SHALL ignore sample_channel and sample_data when sample_valid=0.

Reset
REQ-022 SHALL, while reset=1 at a clock edge, clear all buffer entries, sums, pointers and fill counters to 0, drive side_adc_data, diag_adc_data, side_valid, diag_valid, side_primed and diag_primed to 0, and discard any sample presented that cycle.
REQ-023 SHALL, on reset asserted mid-window, discard all partial history; the first sample after reset starts a new window.

Configuration
REQ-024 SHALL recognise macro ADC_NEG_CLAMP_EN: when defined, a negative sample_data is replaced by 0 before entering the buffer and sum; when undefined, samples are stored unmodified and outputs can be negative.

Verification (WINDOW_LOG2=3)
REQ-025 SHALL cover: reset, then 8 side samples of 0x1000 -> after the 1st sample side_adc_data=0x0200 and side_valid=0; after the 8th sample side_adc_data=0x1000, side_valid pulses once and side_primed rises.
REQ-026 SHALL cover: 8 side samples of 0x0800 interleaved cycle-by-cycle with 8 diag samples of 0x2000 -> final values 0x0800 and 0x2000, one valid pulse per channel, no lost samples.
REQ-027 SHALL cover: primed side window of 0x1000, then one sample 0x1800 -> side_adc_data=0x1100 with side_valid pulse.
REQ-028 SHALL cover: 8 side samples of 0xFFF0 (-16) -> side_adc_data=0xFFF0 without ADC_NEG_CLAMP_EN, and 0x0000 with it.
REQ-029 SHALL cover: 5 side samples of 0x1000, 1-cycle reset, then one sample 0x0800 -> all outputs 0 after reset, then side_adc_data=0x0100, side_primed=0.
REQ-030 SHALL cover: reset held high while sample_valid=1 with 0x7FFF -> no state change; outputs remain 0 after reset release.
